// File: rtl/pack_4x8_to_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pack_4x8_to_32_pkg
// Description : Byte-index type and word helpers shared by the 4x8->32 packer
//               and the 32->4x8 serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package pack_4x8_to_32_pkg;

    localparam int c_BYTE_W = 8;
    localparam int c_WORD_W = 32;
    localparam int c_ACC_W  = 24;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } byte_idx_t;

    // acc holds byte 0 in [7:0], byte 1 in [15:8], byte 2 in [23:16].
    function automatic logic [c_WORD_W-1:0] assemble_word(
        input logic [c_ACC_W-1:0]  acc,
        input logic [c_BYTE_W-1:0] last,
        input logic                lsb_first
    );
        if (lsb_first) begin
            return {last, acc};
        end
        return {acc[7:0], acc[15:8], acc[23:16], last};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pack_4x8_to_32_if.sv
`default_nettype none
// ============================================================================
// Module      : pack_4x8_to_32_if
// Description : Byte-in / word-out handshake bundle for the 4x8->32 packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pack_4x8_to_32_if;
    import pack_4x8_to_32_pkg::*;

    logic                in_valid;
    logic [c_BYTE_W-1:0] indata;
    logic                in_sync;
    logic                in_ready;
    logic                out_valid;
    logic [c_WORD_W-1:0] outdata;
    logic                out_ready;
    logic                sync_err;

    modport master (
        output in_valid, indata, in_sync, out_ready,
        input  in_ready, out_valid, outdata, sync_err
    );

    modport slave (
        input  in_valid, indata, in_sync, out_ready,
        output in_ready, out_valid, outdata, sync_err
    );

endinterface
`default_nettype wire

// File: rtl/pack_4x8_to_32.sv
`default_nettype none
// ============================================================================
// Module      : pack_4x8_to_32
// Description : Packs a synchronised byte stream into 32-bit words with a
//               single registered output stage and valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module pack_4x8_to_32
    import pack_4x8_to_32_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    pack_4x8_to_32_if.slave  bus
);

    byte_idx_t             r_state;
    byte_idx_t             w_state_nxt;
    byte_idx_t             w_slot;
    logic [c_ACC_W-1:0]    r_acc;
    logic [c_WORD_W-1:0]   r_outdata;
    logic                  r_out_valid;
    logic                  r_sync_err;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_acc_we;
    logic                  w_load;
    logic                  w_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only byte 3 can stall: it needs the output register to be free or draining.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b1;
        w_slot      = r_state;
        w_acc_we    = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;

        if (r_state == B3) begin
            w_ready = !r_out_valid || bus.out_ready;
        end
        w_accept = bus.in_valid && w_ready;

        if (w_accept) begin
            if (bus.in_sync) begin
                w_state_nxt = B1;
                w_slot      = B0;
                w_acc_we    = 1'b1;
                w_err       = (r_state != B0);
            end else begin
                case (r_state)
                    B0: begin
                        w_state_nxt = B1;
                        w_acc_we    = 1'b1;
                    end
                    B1: begin
                        w_state_nxt = B2;
                        w_acc_we    = 1'b1;
                    end
                    B2: begin
                        w_state_nxt = B3;
                        w_acc_we    = 1'b1;
                    end
                    default: begin
                        w_state_nxt = B0;
                        w_load      = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_outdata   <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_sync_err <= w_err;

            if (w_acc_we) begin
                case (w_slot)
                    B0:      r_acc[7:0]   <= bus.indata;
                    B1:      r_acc[15:8]  <= bus.indata;
                    B2:      r_acc[23:16] <= bus.indata;
                    default: ;
                endcase
            end

            // A load in the same cycle as a drain keeps out_valid high.
            if (w_load) begin
                r_outdata   <= assemble_word(r_acc, bus.indata, LSB_FIRST != 0);
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.outdata   = r_outdata;
    assign bus.sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_pack_4x8_to_32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pack_4x8_to_32
// Description : Scoreboard bench for both byte orders of the 4x8->32 packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pack_4x8_to_32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pack_4x8_to_32_if bus1 ();
    pack_4x8_to_32_if bus0 ();

    pack_4x8_to_32 #(.LSB_FIRST(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    pack_4x8_to_32 #(.LSB_FIRST(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the word in progress, expected words per order.
    logic [7:0]  part[$];
    logic [31:0] exp1[$];
    logic [31:0] exp0[$];
    bit          held     = 1'b0;
    bit          exp_serr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [7:0] d, input bit r);
        bus1.in_valid = v;  bus0.in_valid = v;
        bus1.in_sync  = s;  bus0.in_sync  = s;
        bus1.indata   = d;  bus0.indata   = d;
        bus1.out_ready = r; bus0.out_ready = r;
    endtask

    // One clock cycle: drive, check current-state outputs, then advance the model.
    task automatic step(input bit v, input bit s, input logic [7:0] d, input bit r,
                        output bit accepted);
        bit er;
        bit wd;
        @(posedge clock);
        #1;
        drive(v, s, d, r);
        #1;
        chk("out_valid_lsb", {31'd0, bus1.out_valid}, {31'd0, held});
        chk("out_valid_msb", {31'd0, bus0.out_valid}, {31'd0, held});
        chk("sync_err_lsb",  {31'd0, bus1.sync_err},  {31'd0, exp_serr});
        chk("sync_err_msb",  {31'd0, bus0.sync_err},  {31'd0, exp_serr});
        er = (part.size() != 3) || !held || r;
        chk("in_ready_lsb",  {31'd0, bus1.in_ready},  {31'd0, er});
        chk("in_ready_msb",  {31'd0, bus0.in_ready},  {31'd0, er});
        accepted = v && er;
        wd       = accepted && !s && (part.size() == 3);
        exp_serr = accepted && s && (part.size() != 0);
        if (accepted) begin
            if (s) part.delete();
            part.push_back(d);
            if (part.size() == 4) begin
                exp1.push_back({part[3], part[2], part[1], part[0]});
                exp0.push_back({part[0], part[1], part[2], part[3]});
                part.delete();
            end
        end
        if (wd) held = 1'b1;
        else if (held && r) held = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(1'b0, 1'b0, 8'h00, 1'b1, a);
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'hE5, 1'b1);
        #1;
        chk("rst_out_valid_lsb", {31'd0, bus1.out_valid}, 32'd0);
        chk("rst_out_valid_msb", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst_outdata_lsb",   bus1.outdata, 32'h0);
        chk("rst_outdata_msb",   bus0.outdata, 32'h0);
        chk("rst_sync_err",      {31'd0, bus1.sync_err}, 32'd0);
        chk("rst_in_ready",      {31'd0, bus1.in_ready}, 32'd1);
        part.delete();
        exp1.delete();
        exp0.delete();
        held     = 1'b0;
        exp_serr = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        chk("rst_hold_in_ready", {31'd0, bus0.in_ready}, 32'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    // Scoreboard monitor: compare the presented word with the queue head
    // every cycle it is valid, pop on handshake.
    always @(negedge clock) begin
        if (bus1.out_valid === 1'b1) begin
            if (exp1.size() == 0) chk("word_lsb_unexpected", bus1.outdata, 32'hxxxxxxxx);
            else begin
                chk("word_lsb", bus1.outdata, exp1[0]);
                if (bus1.out_ready) void'(exp1.pop_front());
            end
        end
        if (bus0.out_valid === 1'b1) begin
            if (exp0.size() == 0) chk("word_msb_unexpected", bus0.outdata, 32'hxxxxxxxx);
            else begin
                chk("word_msb", bus0.outdata, exp0[0]);
                if (bus0.out_ready) void'(exp0.pop_front());
            end
        end
    end

    initial begin
        bit a;
        int i;
        int cyc;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        do_reset(3);

        // Basic word, both byte orders.
        step(1'b1, 1'b1, 8'h11, 1'b1, a);
        step(1'b1, 1'b0, 8'h22, 1'b1, a);
        step(1'b1, 1'b0, 8'h33, 1'b1, a);
        step(1'b1, 1'b0, 8'h44, 1'b1, a);
        idle(3);

        // Resync discards a partial word.
        step(1'b1, 1'b1, 8'hAA, 1'b1, a);
        step(1'b1, 1'b0, 8'hBB, 1'b1, a);
        step(1'b1, 1'b1, 8'h01, 1'b1, a);
        step(1'b1, 1'b0, 8'h02, 1'b1, a);
        step(1'b1, 1'b0, 8'h03, 1'b1, a);
        step(1'b1, 1'b0, 8'h04, 1'b1, a);
        idle(3);

        // Backpressure: two words, consumer stalled for 12 cycles.
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 40) begin
            step(1'b1, (i % 4) == 0, 8'(8'h11 * (i + 1)), cyc >= 12, a);
            if (a) i++;
            cyc++;
        end
        chk("backpressure_bytes_sent", i, 8);
        idle(4);

        // Continuous stream 00..0F.
        for (int k = 0; k < 16; k++) step(1'b1, (k % 4) == 0, 8'(k), 1'b1, a);
        idle(3);

        // Reset mid-word.
        step(1'b1, 1'b1, 8'hAA, 1'b1, a);
        step(1'b1, 1'b0, 8'hBB, 1'b1, a);
        do_reset(2);
        for (int k = 1; k <= 4; k++) step(1'b1, k == 1, 8'(k), 1'b1, a);
        idle(3);

        // Reset with an undrained word pending.
        for (int k = 0; k < 4; k++) step(1'b1, k == 0, 8'(8'hC0 + k), 1'b0, a);
        idle(0);
        step(1'b0, 1'b0, 8'h00, 1'b0, a);
        do_reset(1);
        idle(3);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                 8'($urandom), $urandom_range(0, 9) < 6, a);
        end
        idle(6);

        chk("lsb_queue_empty", exp1.size(), 32'd0);
        chk("msb_queue_empty", exp0.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
